// File: rtl/branch_resolver.sv
// Branch resolution stage: evaluates the branch condition, checks it against
// static BTFN prediction, and issues a redirect/flush on a mispredict.
module branch_resolver #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_func,
  input  logic [XLEN-1:0]  br_a,
  input  logic [XLEN-1:0]  br_b,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_imm,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush,
  output logic             illegal,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispred
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      func_q;
  logic [XLEN-1:0] a_q, b_q, pc_q, imm_q;
  logic            eq, lt, ltu, taken, legal, mispred;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_comb begin
    eq    = (a_q == b_q);
    lt    = ($signed(a_q) < $signed(b_q));
    ltu   = (a_q < b_q);
    taken = 1'b0;
    legal = 1'b1;
    case (func_q)
      3'd0:    taken = eq;
      3'd1:    taken = !eq;
      3'd4:    taken = lt;
      3'd5:    taken = !lt;
      3'd6:    taken = ltu;
      3'd7:    taken = !ltu;
      default: legal = 1'b0;
    endcase
    // Backward branches (negative offset) are predicted taken.
    mispred = legal && (taken != imm_q[XLEN-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (br_valid) state_nxt = EVAL;
      EVAL:     state_nxt = mispred ? REDIRECT : IDLE;
      REDIRECT: if (redir_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign br_ready    = (state == IDLE);
  assign redir_valid = (state == REDIRECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      func_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      redir_pc    <= '0;
      flush       <= 1'b0;
      illegal     <= 1'b0;
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else begin
      flush   <= 1'b0;
      illegal <= 1'b0;
      if (state == IDLE && br_valid) begin
        func_q <= br_func;
        a_q    <= br_a;
        b_q    <= br_b;
        pc_q   <= br_pc;
        imm_q  <= br_imm;
      end
      if (state == EVAL) begin
        if (!legal) begin
          illegal <= 1'b1;
        end else begin
          if (cnt_branch != CNT_MAX) cnt_branch <= cnt_branch + CNT_W'(1);
          if (mispred) begin
            if (cnt_mispred != CNT_MAX) cnt_mispred <= cnt_mispred + CNT_W'(1);
            redir_pc <= taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));
            // Flush is raised only on entry to REDIRECT, so it is a single pulse.
            flush    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: vector table plus stall/reset sequences.
// A second instance with 3-bit counters exercises counter saturation.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, redir_ready;
  logic [2:0]  br_func;
  logic [31:0] br_a, br_b, br_pc, br_imm;
  logic        br_ready, redir_valid, flush, illegal;
  logic [31:0] redir_pc, cnt_branch, cnt_mispred;
  logic        s_br_ready, s_redir_valid, s_flush, s_illegal;
  logic [31:0] s_redir_pc;
  logic [2:0]  s_cnt_branch, s_cnt_mispred;

  always #5 clk = ~clk;

  branch_resolver #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
    .br_func(br_func), .br_a(br_a), .br_b(br_b), .br_pc(br_pc), .br_imm(br_imm),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush(flush), .illegal(illegal), .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  branch_resolver #(.XLEN(32), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(s_br_ready),
    .br_func(br_func), .br_a(br_a), .br_b(br_b), .br_pc(br_pc), .br_imm(br_imm),
    .redir_valid(s_redir_valid), .redir_ready(redir_ready), .redir_pc(s_redir_pc),
    .flush(s_flush), .illegal(s_illegal), .cnt_branch(s_cnt_branch), .cnt_mispred(s_cnt_mispred)
  );

  typedef struct {
    logic [2:0]  func;
    logic [31:0] a, b, pc, imm;
    bit          mis;
    bit          ill;
    logic [31:0] rpc;
  } vec_t;

  vec_t vt[12];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_br = 0;
  int   exp_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_counters();
    chk("cnt_branch", cnt_branch, 32'(exp_br));
    chk("cnt_mispred", cnt_mispred, 32'(exp_mis));
    chk("sat_cnt_branch", {29'd0, s_cnt_branch}, (exp_br > 7) ? 32'd7 : 32'(exp_br));
    chk("sat_cnt_mispred", {29'd0, s_cnt_mispred}, (exp_mis > 7) ? 32'd7 : 32'(exp_mis));
  endtask

  task automatic offer(input vec_t v);
    br_func  = v.func;
    br_a     = v.a;
    br_b     = v.b;
    br_pc    = v.pc;
    br_imm   = v.imm;
    br_valid = 1'b1;
  endtask

  initial begin
    vt[0]  = '{3'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0100, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0108};
    vt[1]  = '{3'd4, 32'h8000_00FF, 32'h0000_01FF, 32'h0000_0200, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{3'd6, 32'h8000_00FF, 32'h0000_01FF, 32'h0000_0200, 32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0000_0204};
    vt[3]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0008};
    vt[4]  = '{3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0300, 32'h0000_0008, 1'b0, 1'b0, 32'h0};
    vt[5]  = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0400, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0000_0404};
    vt[6]  = '{3'd2, 32'h0000_0001, 32'h0000_0002, 32'h0000_0480, 32'h0000_0008, 1'b0, 1'b1, 32'h0};
    vt[7]  = '{3'd3, 32'h0000_0001, 32'h0000_0001, 32'h0000_0490, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'h0};
    vt[8]  = '{3'd0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0500, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0504};
    vt[9]  = '{3'd4, 32'h0000_0001, 32'h0000_0002, 32'h0000_0600, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0620};
    vt[10] = '{3'd7, 32'h0000_0000, 32'h0000_0001, 32'h0000_0700, 32'hFFFF_FFE0, 1'b1, 1'b0, 32'h0000_0704};
    vt[11] = '{3'd1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0800, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0840};

    rst = 1'b1; br_valid = 1'b0; redir_ready = 1'b0;
    br_func = '0; br_a = '0; br_b = '0; br_pc = '0; br_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk_counters();

    foreach (vt[i]) begin
      offer(vt[i]);
      @(posedge clk);                 // accept edge N
      @(negedge clk);
      br_valid = 1'b0;
      chk($sformatf("v%0d_eval_ready", i), {31'd0, br_ready}, 32'd0);
      chk($sformatf("v%0d_eval_rv", i), {31'd0, redir_valid}, 32'd0);
      @(posedge clk);                 // outcome edge N+1
      @(negedge clk);
      chk($sformatf("v%0d_rv", i), {31'd0, redir_valid}, {31'd0, vt[i].mis});
      chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vt[i].mis});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vt[i].ill});
      chk($sformatf("v%0d_ready", i), {31'd0, br_ready}, {31'd0, !vt[i].mis});
      if (!vt[i].ill) exp_br++;
      if (vt[i].mis) begin
        exp_mis++;
        chk($sformatf("v%0d_redir_pc", i), redir_pc, vt[i].rpc);
        redir_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        redir_ready = 1'b0;
        chk($sformatf("v%0d_ret_ready", i), {31'd0, br_ready}, 32'd1);
        chk($sformatf("v%0d_ret_rv", i), {31'd0, redir_valid}, 32'd0);
        chk($sformatf("v%0d_ret_flush", i), {31'd0, flush}, 32'd0);
      end else begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_ill_once", i), {31'd0, illegal}, 32'd0);
      end
      chk_counters();
    end

    // Stalled redirect: fetch holds redir_ready low while decode keeps offering.
    redir_ready = 1'b1;               // ignored in IDLE
    @(posedge clk);
    @(negedge clk);
    chk("idle_rr_ignored", {31'd0, redir_valid}, 32'd0);
    redir_ready = 1'b0;
    offer(vt[0]);
    @(posedge clk);
    @(negedge clk);
    offer(vt[4]);
    @(posedge clk);
    @(negedge clk);
    exp_br++; exp_mis++;
    chk("stall_flush_first", {31'd0, flush}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_rv", c), {31'd0, redir_valid}, 32'd1);
      chk($sformatf("stall%0d_pc", c), redir_pc, 32'h0000_0108);
      chk($sformatf("stall%0d_ready", c), {31'd0, br_ready}, 32'd0);
      if (c > 0) chk($sformatf("stall%0d_flush", c), {31'd0, flush}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    chk_counters();
    br_valid = 1'b0;
    redir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    redir_ready = 1'b0;
    chk("stall_release_ready", {31'd0, br_ready}, 32'd1);
    chk("stall_release_rv", {31'd0, redir_valid}, 32'd0);
    chk_counters();

    // Reset while a redirect is pending.
    offer(vt[9]);
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_rv", {31'd0, redir_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_br = 0; exp_mis = 0;
    chk("post_rst_rv", {31'd0, redir_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, br_ready}, 32'd1);
    chk("post_rst_pc", redir_pc, 32'd0);
    chk("post_rst_flush", {31'd0, flush}, 32'd0);
    chk_counters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
